// File: rtl/pcm_playback.sv
// pcm_playback: consumer side of the audio byte FIFO.
//
// On each accepted output-sample tick a phase accumulator advances by the sample
// rate. A carry starts a fetch of 1, 2 or 4 bytes from the FIFO. The bytes are
// assembled into signed 16-bit left/right samples, scaled by a volume gain and
// presented as registered stereo samples for the DAC serializer.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_next_sample  one-cycle tick per output sample period
//   i_sample_rate  phase increment (0 = paused, values above 128 act as 128)
//   i_mode_stereo  1 = interleaved L,R; 0 = mono duplicated to both channels
//   i_mode_16bit   1 = 16-bit little-endian samples; 0 = 8-bit signed samples
//   i_volume       gain index 0..15
//   i_fifo_rddata  FIFO read data, valid the cycle after o_fifo_rd_en
//   i_fifo_empty   FIFO empty flag
//   o_fifo_rd_en   FIFO read strobe, one byte per asserted cycle
//   o_left_out     registered signed left sample
//   o_right_out    registered signed right sample
//   o_out_valid    one-cycle pulse when the outputs update
//   o_underrun     one-cycle pulse when a fetch is aborted on an empty FIFO
module pcm_playback (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_next_sample,
  input  logic [7:0]  i_sample_rate,
  input  logic        i_mode_stereo,
  input  logic        i_mode_16bit,
  input  logic [3:0]  i_volume,
  input  logic [7:0]  i_fifo_rddata,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  output logic [15:0] o_left_out,
  output logic [15:0] o_right_out,
  output logic        o_out_valid,
  output logic        o_underrun
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_OUTPUT  = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_acc;
  logic        r_stereo;
  logic        r_16bit;
  logic [2:0]  r_rd_cnt;
  logic [1:0]  r_cap_idx;
  logic        r_cap_pending;
  logic        r_abort;
  logic [7:0]  r_bytes [4];
  logic [15:0] r_left;
  logic [15:0] r_right;
  logic        r_out_valid;
  logic        r_underrun;

  logic [7:0]  w_rate;
  logic [7:0]  w_sum;
  logic [2:0]  w_n;
  logic [6:0]  w_gain;
  logic [15:0] w_left_raw;
  logic [15:0] w_right_raw;

  function automatic logic [6:0] gain_lut(input logic [3:0] vol);
    logic [6:0] g;
    case (vol)
      4'd0:    g = 7'd0;
      4'd1:    g = 7'd1;
      4'd2:    g = 7'd2;
      4'd3:    g = 7'd3;
      4'd4:    g = 7'd4;
      4'd5:    g = 7'd5;
      4'd6:    g = 7'd6;
      4'd7:    g = 7'd8;
      4'd8:    g = 7'd11;
      4'd9:    g = 7'd14;
      4'd10:   g = 7'd18;
      4'd11:   g = 7'd23;
      4'd12:   g = 7'd30;
      4'd13:   g = 7'd38;
      4'd14:   g = 7'd49;
      default: g = 7'd64;
    endcase
    return g;
  endfunction

  // Gain is an unsigned 0..64 value; a zero sign bit keeps 64 positive in the
  // signed multiply. |sample*gain| <= 2^21, so no product bits are lost.
  function automatic logic [15:0] apply_gain(input logic [15:0] s, input logic [6:0] g);
    logic signed [23:0] p;
    p = 24'($signed(s)) * 24'($signed({1'b0, g}));
    return 16'(p >>> 6);
  endfunction

  assign w_rate = (i_sample_rate > 8'd128) ? 8'd128 : i_sample_rate;
  // r_acc never exceeds 127, so the 8-bit sum cannot wrap; bit 7 is the carry.
  assign w_sum  = r_acc + w_rate;
  assign w_gain = gain_lut(i_volume);

  always_comb begin
    unique case ({r_16bit, r_stereo})
      2'b00:   w_n = 3'd1;
      2'b11:   w_n = 3'd4;
      default: w_n = 3'd2;
    endcase
  end

  assign w_left_raw  = r_16bit ? {r_bytes[1], r_bytes[0]} : {r_bytes[0], 8'h00};
  assign w_right_raw = !r_stereo ? w_left_raw :
                       (r_16bit ? {r_bytes[3], r_bytes[2]} : {r_bytes[1], 8'h00});

  // Reset gates the strobe so no byte is consumed by a fetch being aborted.
  assign o_fifo_rd_en = (r_state == ST_READ) && !i_fifo_empty && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_acc         <= 8'd0;
      r_stereo      <= 1'b0;
      r_16bit       <= 1'b0;
      r_rd_cnt      <= 3'd0;
      r_cap_idx     <= 2'd0;
      r_cap_pending <= 1'b0;
      r_abort       <= 1'b0;
      for (int i = 0; i < 4; i++) r_bytes[i] <= 8'h00;
      r_left        <= 16'h0000;
      r_right       <= 16'h0000;
      r_out_valid   <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_out_valid   <= 1'b0;
      r_underrun    <= 1'b0;
      // Read data lands one cycle after the strobe; store it in arrival order.
      r_cap_pending <= o_fifo_rd_en;
      if (r_cap_pending) begin
        r_bytes[r_cap_idx] <= i_fifo_rddata;
        r_cap_idx          <= r_cap_idx + 2'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_next_sample) begin
            r_acc <= {1'b0, w_sum[6:0]};
            if (w_sum[7]) begin
              r_state   <= ST_READ;
              r_stereo  <= i_mode_stereo;
              r_16bit   <= i_mode_16bit;
              r_rd_cnt  <= 3'd0;
              r_cap_idx <= 2'd0;
              r_abort   <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (i_fifo_empty) begin
            // A byte is still owed but none is available: abandon the fetch.
            r_abort <= 1'b1;
            r_state <= ST_OUTPUT;
          end else begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
            if (r_rd_cnt + 3'd1 == w_n) r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_state <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (r_abort) begin
            r_left     <= 16'h0000;
            r_right    <= 16'h0000;
            r_underrun <= 1'b1;
          end else begin
            r_left  <= apply_gain(w_left_raw, w_gain);
            r_right <= apply_gain(w_right_raw, w_gain);
          end
          r_out_valid <= 1'b1;
          r_abort     <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_left_out  = r_left;
  assign o_right_out = r_right;
  assign o_out_valid = r_out_valid;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_pcm_playback.sv
// Directed bench for pcm_playback: a byte-FIFO model feeds the DUT, and each
// sample tick is followed by a fixed 16-cycle window in which read strobes,
// out_valid latency and underrun pulses are observed.
module tb_pcm_playback;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_sample;
  logic [7:0]  sample_rate;
  logic        mode_stereo;
  logic        mode_16bit;
  logic [3:0]  volume;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        out_valid;
  logic        underrun;

  always #5 clk = ~clk;

  pcm_playback dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_next_sample (next_sample),
    .i_sample_rate (sample_rate),
    .i_mode_stereo (mode_stereo),
    .i_mode_16bit  (mode_16bit),
    .i_volume      (volume),
    .i_fifo_rddata (fifo_rddata),
    .i_fifo_empty  (fifo_empty),
    .o_fifo_rd_en  (fifo_rd_en),
    .o_left_out    (left_out),
    .o_right_out   (right_out),
    .o_out_valid   (out_valid),
    .o_underrun    (underrun)
  );

  // FIFO model and event counters.
  logic [7:0] mem [0:63];
  int wr_ptr;
  int rd_ptr;
  int cyc;
  int rd_cnt;
  int rd_last;
  int vcnt;
  int ucnt;
  int bad_rd;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      rd_last <= cyc;
      if (!fifo_empty) begin
        fifo_rddata <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end else begin
        bad_rd <= bad_rd + 1;
      end
    end
    if (out_valid) vcnt <= vcnt + 1;
    if (underrun)  ucnt <= ucnt + 1;
  end

  int n_checks;
  int n_fail;
  int last_t0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  // One tick, then a 16-cycle observation window. lat = cycles from the tick
  // to out_valid (-1 if none).
  task automatic do_tick(output int lat, output int reads, output int valids, output int unds);
    int t0, r0, v0, u0;
    @(negedge clk);
    t0 = cyc; r0 = rd_cnt; v0 = vcnt; u0 = ucnt;
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    lat = -1;
    while (cyc < t0 + 16) begin
      if (out_valid && lat < 0) lat = cyc - t0;
      @(negedge clk);
    end
    reads   = rd_cnt - r0;
    valids  = vcnt - v0;
    unds    = ucnt - u0;
    last_t0 = t0;
  endtask

  int lat, rds, vls, uds, t0, r0, v0;
  int sum_r, sum_v;
  int exp_lat [4];
  int exp_rds [4];

  initial begin
    rst = 1'b1; next_sample = 1'b0; sample_rate = 8'd128;
    mode_stereo = 1'b0; mode_16bit = 1'b0; volume = 4'd15;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset left", 32'(left_out), 32'h0);
    check_eq("reset right", 32'(right_out), 32'h0);
    check_eq("reset valid", 32'(out_valid), 32'h0);
    check_eq("reset underrun", 32'(underrun), 32'h0);
    check_eq("reset rd_en", 32'(fifo_rd_en), 32'h0);

    // 8-bit mono, rate 128, full volume.
    push(8'h80); push(8'h7F);
    do_tick(lat, rds, vls, uds);
    check_eq("m8 tick1 lat", lat, 4);
    check_eq("m8 tick1 reads", rds, 1);
    check_eq("m8 tick1 valids", vls, 1);
    check_eq("m8 tick1 L", 32'(left_out), 32'h8000);
    check_eq("m8 tick1 R", 32'(right_out), 32'h8000);
    do_tick(lat, rds, vls, uds);
    check_eq("m8 tick2 reads", rds, 1);
    check_eq("m8 tick2 L", 32'(left_out), 32'h7F00);
    check_eq("m8 tick2 R", 32'(right_out), 32'h7F00);

    // 16-bit stereo.
    mode_stereo = 1'b1; mode_16bit = 1'b1;
    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    do_tick(lat, rds, vls, uds);
    check_eq("s16 lat", lat, 7);
    check_eq("s16 reads", rds, 4);
    check_eq("s16 last read cycle", rd_last - last_t0, 4);
    check_eq("s16 L", 32'(left_out), 32'h1234);
    check_eq("s16 R", 32'(right_out), 32'h5678);

    // Rate 64: fetch on every second tick.
    mode_stereo = 1'b0; mode_16bit = 1'b0; sample_rate = 8'd64;
    push(8'h11); push(8'h22);
    exp_lat = '{-1, 4, -1, 4};
    exp_rds = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      do_tick(lat, rds, vls, uds);
      check_eq($sformatf("r64 tick%0d lat", i + 1), lat, exp_lat[i]);
      check_eq($sformatf("r64 tick%0d reads", i + 1), rds, exp_rds[i]);
      if (i == 1) check_eq("r64 L after tick2", 32'(left_out), 32'h1100);
      if (i == 3) check_eq("r64 L after tick4", 32'(left_out), 32'h2200);
    end

    // Rate 0 pauses: acc parked at 64 must survive ten paused ticks.
    do_tick(lat, rds, vls, uds);
    check_eq("pre-pause no fetch", lat, -1);
    sample_rate = 8'd0;
    push(8'h33);
    sum_r = 0; sum_v = 0;
    for (int i = 0; i < 10; i++) begin
      do_tick(lat, rds, vls, uds);
      sum_r += rds; sum_v += vls;
    end
    check_eq("pause reads", sum_r, 0);
    check_eq("pause valids", sum_v, 0);
    sample_rate = 8'd64;
    do_tick(lat, rds, vls, uds);
    check_eq("post-pause lat", lat, 4);
    check_eq("post-pause L", 32'(left_out), 32'h3300);

    // Rate 200 acts as 128: from acc 64 it must carry and leave acc at 64.
    push(8'h44); push(8'h55);
    do_tick(lat, rds, vls, uds);
    check_eq("r200 pre no fetch", lat, -1);
    sample_rate = 8'd200;
    do_tick(lat, rds, vls, uds);
    check_eq("r200 lat", lat, 4);
    check_eq("r200 L", 32'(left_out), 32'h4400);
    sample_rate = 8'd64;
    do_tick(lat, rds, vls, uds);
    check_eq("r200 after lat", lat, 4);
    check_eq("r200 after L", 32'(left_out), 32'h5500);

    // Volume sweep, 16-bit mono.
    sample_rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b0;
    volume = 4'd0;  push(8'h00); push(8'h40);
    do_tick(lat, rds, vls, uds);
    check_eq("vol0 lat", lat, 5);
    check_eq("vol0 L", 32'(left_out), 32'h0000);
    volume = 4'd7;  push(8'h00); push(8'h40);
    do_tick(lat, rds, vls, uds);
    check_eq("vol7 L", 32'(left_out), 32'h0800);
    check_eq("vol7 R", 32'(right_out), 32'h0800);
    volume = 4'd15; push(8'h00); push(8'h40);
    do_tick(lat, rds, vls, uds);
    check_eq("vol15 L", 32'(left_out), 32'h4000);
    volume = 4'd7;  push(8'h00); push(8'hC0);
    do_tick(lat, rds, vls, uds);
    check_eq("vol7 neg L", 32'(left_out), 32'hF800);
    check_eq("vol7 neg R", 32'(right_out), 32'hF800);

    // Underrun: 16-bit stereo with only two bytes available.
    volume = 4'd15; mode_stereo = 1'b1;
    push(8'hAA); push(8'hBB);
    do_tick(lat, rds, vls, uds);
    check_eq("udr reads", rds, 2);
    check_eq("udr underruns", uds, 1);
    check_eq("udr valids", vls, 1);
    check_eq("udr lat", lat, 5);
    check_eq("udr L", 32'(left_out), 32'h0);
    check_eq("udr R", 32'(right_out), 32'h0);
    check_eq("udr fifo level", wr_ptr - rd_ptr, 0);
    do_tick(lat, rds, vls, uds);
    check_eq("udr2 reads", rds, 0);
    check_eq("udr2 underruns", uds, 1);
    check_eq("udr2 lat", lat, 3);

    // A tick during an active fetch is ignored.
    push(8'h34); push(8'h12); push(8'h78); push(8'h56); push(8'h9A); push(8'hBC);
    @(negedge clk);
    t0 = cyc; r0 = rd_cnt; v0 = vcnt;
    next_sample = 1'b1;
    @(negedge clk); next_sample = 1'b0;
    @(negedge clk); next_sample = 1'b1;
    @(negedge clk); next_sample = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    check_eq("busy tick reads", rd_cnt - r0, 4);
    check_eq("busy tick valids", vcnt - v0, 1);
    check_eq("busy tick L", 32'(left_out), 32'h1234);
    check_eq("busy tick R", 32'(right_out), 32'h5678);
    check_eq("busy tick fifo level", wr_ptr - rd_ptr, 2);
    flush();

    // Reset mid-fetch; park acc at 64 first so a clean restart is visible.
    sample_rate = 8'd64;
    do_tick(lat, rds, vls, uds);
    check_eq("rst pre no fetch", lat, -1);
    sample_rate = 8'd128;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk); next_sample = 1'b0;
    check_eq("rst mid rd_en before", 32'(fifo_rd_en), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_eq("rst rd_en after", 32'(fifo_rd_en), 32'h0);
    check_eq("rst L", 32'(left_out), 32'h0);
    check_eq("rst R", 32'(right_out), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst no valid", vcnt - v0, 1);
    flush();
    mode_stereo = 1'b0; mode_16bit = 1'b0; sample_rate = 8'd64;
    push(8'h66);
    do_tick(lat, rds, vls, uds);
    check_eq("restart tick1 lat", lat, -1);
    check_eq("restart tick1 reads", rds, 0);
    do_tick(lat, rds, vls, uds);
    check_eq("restart tick2 lat", lat, 4);
    check_eq("restart tick2 L", 32'(left_out), 32'h6600);

    check_eq("rd_en while empty", bad_rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_playback.md
# pcm_playback

Downstream consumer of the audio byte FIFO. On each output-sample tick it advances a sample-rate phase accumulator. When the accumulator carries, it pulls 1, 2 or 4 bytes from the FIFO. It assembles them into signed 16-bit left/right samples, applies a 4-bit volume, and presents registered stereo samples to the DAC serializer.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- next_sample  in  1  single-cycle tick from the DAC serializer, one per output sample period; spacing is at least 16 clk.
- sample_rate  in  8  phase increment; 0 = paused, 1..128 linear, values >128 are treated as 128.
- mode_stereo  in  1  1 = interleaved L,R; 0 = mono, duplicated to both channels.
- mode_16bit  in  1  1 = 16-bit little-endian samples; 0 = 8-bit signed samples.
- volume  in  4  gain index.
- fifo_rddata  in  8  FIFO read data, valid on the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe, one byte per asserted cycle.
- left_out  out  16  signed left sample, registered.
- right_out  out  16  signed right sample, registered.
- out_valid  out  1  one-cycle pulse when left_out/right_out update.
- underrun  out  1  one-cycle pulse when a fetch is aborted on empty.

## Operation
- Accumulator acc: 8-bit register.
  - On each accepted next_sample: sum = acc + min(sample_rate,128).
  - acc <= sum[6:0], zero-extended.
  - A carry (sum[7]=1) starts a fetch.
  - When sample_rate = 0, acc holds and no fetch starts.
- Byte count n is set at fetch start: 1 (8-bit mono), 2 (8-bit stereo or 16-bit mono), 4 (16-bit stereo).
- mode_stereo and mode_16bit are latched at fetch start. Changes during a fetch take effect on the next fetch.
- Byte order:
  - 8-bit stereo: L, R.
  - 16-bit mono: lo, hi.
  - 16-bit stereo: Llo, Lhi, Rlo, Rhi.
- 8-bit sample b widens to {b,8'h00}.
- In mono mode, left = right = the assembled sample.
- FSM states:
  - IDLE: waits for a carry, then goes to READ.
  - READ: asserts fifo_rd_en for byte k when fifo_empty=0. After n reads it goes to CAPTURE.
  - CAPTURE: takes the last byte and goes to OUTPUT.
  - OUTPUT: applies gain, registers the outputs, pulses out_valid, then returns to IDLE.
  - Bytes are captured from fifo_rddata one cycle after each read.
- Gain table for volume 0..15: 0,1,2,3,4,5,6,8,11,14,18,23,30,38,49,64.
  - out = (sample * gain) >>> 6, using a signed 16x7 multiply and a 23-bit product, arithmetic shift, then truncation to 16 bits.
  - Gain 64 is an exact passthrough.
  - No saturation is needed.
- Underrun: fifo_empty is checked before issuing each read.
  - If the FIFO is empty while a read is still owed, the fetch aborts.
  - No further reads are issued; already-consumed bytes are discarded.
  - left_out and right_out are set to 0, underrun pulses, out_valid pulses, and the FSM returns to IDLE.
  - The byte alignment of the FIFO stream is the software's responsibility. Software resets it with the FIFO's read-reset.
- A next_sample arriving while not in IDLE is ignored: no accumulator update and no fetch.

## Timing
- Reset values: acc=0, FSM=IDLE, fifo_rd_en=0, left_out=0, right_out=0, out_valid=0, underrun=0. Latched modes are cleared to 8-bit mono.
- A reset during a fetch aborts it immediately. No fifo_rd_en is asserted on the cycle after reset.
- next_sample in cycle T with a carry:
  - fifo_rd_en is high for cycles T+1..T+n, contiguous while the FIFO is non-empty.
  - Bytes arrive in cycles T+2..T+n+1.
  - left_out, right_out and out_valid are visible in cycle T+n+3.
  - Latency is 4 cycles for n=1 and 7 cycles for n=4.
- Underrun detected in cycle T+k:
  - fifo_rd_en stays low from T+k on.
  - Zero outputs, underrun and out_valid are visible in cycle T+k+2.
- out_valid and underrun are high for exactly one cycle. The outputs hold their value between updates.
- fifo_rd_en is never asserted while fifo_empty=1 and is never asserted in IDLE.

## Test plan
- 8-bit mono, rate 128, volume 15, FIFO holds 8'h80 then 8'h7F:
  - two ticks give L=R=16'h8000, then L=R=16'h7F00;
  - one fifo_rd_en per tick;
  - out_valid in cycle T+4.
- 16-bit stereo, rate 128, volume 15, bytes 34 12 78 56:
  - L=16'h1234, R=16'h5678;
  - fifo_rd_en high for 4 cycles;
  - out_valid in cycle T+7.
- Rate 64:
  - a fetch occurs on every second tick (2nd, 4th, ...);
  - rate 0 for 10 ticks gives zero reads and acc unchanged;
  - rate 200 behaves exactly like 128.
- Volume sweep with 16-bit mono sample 16'h4000:
  - volume 0 gives 0, volume 7 gives 16'h0800, volume 15 gives 16'h4000;
  - negative sample 16'hC000 at volume 7 gives 16'hF800.
- Underrun: 16-bit stereo with only 2 bytes in the FIFO:
  - exactly 2 reads;
  - underrun and out_valid pulse with L=R=0;
  - the FIFO is left empty;
  - the next tick with an empty FIFO issues zero reads and pulses underrun again.
- Mid-operation events:
  - a tick during an active fetch is ignored, and the outputs match a single fetch;
  - rst asserted mid-fetch: fifo_rd_en drops on the next cycle, outputs are 0, and a later tick restarts cleanly from acc=0.
